run_ctrl: RTL and testbench
===========================

# run_ctrl

Run controller for the single-cycle datapath. It accepts a four-phase run request from the host or testbench and holds the datapath in init by driving its START input. It then releases the datapath, counts execution cycles until the datapath raises DONE, and enforces a cycle-limit watchdog. It also inhibits architectural writes whenever the datapath is not legitimately executing. It sits between the top level and `datapath`: `dp_start` drives START, `dp_done` comes from DONE, and `wr_inhibit` gates CTRL_reg_write_en and CTRL_write_mem.

## Interface
Parameters:
- `START_CYCLES`, default 2: cycles START is held high after a request is accepted; legal range ≥1.
- `CNT_W`, default 16: width of the cycle counter.
- `MAX_CYCLES`, default 20000: watchdog limit in RUN cycles; legal range 1..2^CNT_W−1.

Ports:
- `CLK`, in, 1: the single clock; every register updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, 1: run request, four-phase; held high until `ack` is seen, then dropped.
- `dp_done`, in, 1: DONE from the datapath.
- `dp_start`, out, 1: drives datapath START; high parks the datapath (PC init, flags and memory reset).
- `wr_inhibit`, out, 1: high forces reg-file and data-memory write enables low.
- `busy`, out, 1: a run has been accepted and is not yet acknowledged.
- `ack`, out, 1: one-cycle pulse marking run completion.
- `timeout`, out, 1: the last run ended by watchdog.
- `cycle_count`, out, CNT_W: number of RUN cycles of the current or last run.

## Operation
- FSM states: IDLE, INIT, RUN, FINISH, DRAIN. All outputs are registered and are functions of state plus held registers.
- IDLE:
  - Outputs: `dp_start`=1, `wr_inhibit`=1, `busy`=0.
  - `req`=1 → INIT. On this transition: `cycle_count`←0, `timeout`←0, init counter ← START_CYCLES−1.
- INIT:
  - Outputs: `dp_start`=1, `wr_inhibit`=1, `busy`=1.
  - The init counter decrements each cycle. Init counter = 0 → RUN.
- RUN:
  - Outputs: `dp_start`=0, `wr_inhibit`=0, `busy`=1.
  - Every RUN cycle: `cycle_count`←`cycle_count`+1.
  - `dp_done`=1 → FINISH with `timeout`=0.
  - Otherwise, if `cycle_count`+1 == MAX_CYCLES → FINISH with `timeout`←1.
- FINISH, exactly one cycle:
  - Outputs: `ack`=1, `busy`=1, `dp_start`=1, `wr_inhibit`=1.
  - Always → DRAIN.
- DRAIN:
  - Outputs: `ack`=0, `busy`=0, `dp_start`=1, `wr_inhibit`=1.
  - `req`=0 → IDLE. While `req` is held high, the block stays in DRAIN; no restart is possible without `req` going low.
- `dp_done` is ignored in IDLE, INIT, FINISH and DRAIN, because a stale DONE from the previous program must not end a new run.
- `cycle_count` and `timeout` hold their values after FINISH until the next request is accepted.
- Width rule: the counter never wraps. MAX_CYCLES ≤ 2^CNT_W−1 guarantees the watchdog fires before overflow.

## Timing
- Reset values:
  - State = IDLE.
  - `dp_start`=1, `wr_inhibit`=1, `busy`=0, `ack`=0, `timeout`=0, `cycle_count`=0.
  - `reset` overrides every other input, including mid-run. The cycle after `reset` is sampled high shows the reset values, regardless of state.
- Request latency:
  - `req` is sampled high at edge k in IDLE. `busy`=1 from edge k+1.
  - `dp_start` falls at edge k+1+START_CYCLES; that cycle is RUN cycle 1.
- Completion latency:
  - `dp_done` sampled high at the edge ending RUN cycle n gives `cycle_count`=n and `ack`=1 in the next cycle.
  - `dp_start` returns high in that same cycle.
- Simultaneous events:
  - `dp_done`=1 on the limit cycle: done wins, `timeout`=0, `cycle_count`=MAX_CYCLES.
  - `dp_done`=1 on RUN cycle 1 is accepted, giving `cycle_count`=1.
- MAX_CYCLES=1: the run ends after exactly 1 RUN cycle, with `timeout`=1 unless `dp_done` is high in that cycle.

## Test plan
- **Reset:** assert `reset` for 1 cycle with random inputs → `dp_start`=1, `wr_inhibit`=1, `busy`=0, `ack`=0, `timeout`=0, `cycle_count`=0.
- **Normal run:** START_CYCLES=2; raise `req` at edge 0; pulse `dp_done` at the end of RUN cycle 10 → `dp_start` is high in cycles 1–2 and low in cycles 3–12; `ack`=1 for exactly 1 cycle; `cycle_count`=10; `timeout`=0; `wr_inhibit`=0 only during RUN.
- **Watchdog:** MAX_CYCLES=20 with `dp_done` held at 0 → `ack` pulses after RUN cycle 20; `cycle_count`=20; `timeout`=1; `dp_start` returns to 1.
- **Done on the limit cycle:** MAX_CYCLES=20 with `dp_done`=1 on RUN cycle 20 → `timeout`=0 and `cycle_count`=20.
- **Handshake:**
  - Hold `req` high for 50 cycles after `ack` → no second run (`busy`=0, `dp_start`=1).
  - Then drop `req` for 1 cycle and raise it again → a new run starts; `cycle_count` clears to 0 and `timeout` clears on accept.
- **Reset mid-run and stale DONE:**
  - Assert `reset` in RUN cycle 5 → reset values in the next cycle, with no `ack`.
  - Hold `dp_done`=1 throughout IDLE and INIT → the run still lasts until a `dp_done` sampled in RUN, giving `cycle_count`=1.

Source files
------------

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run controller: four-phase run request, datapath init hold, cycle count, watchdog
// All outputs are flops loaded from the next-state decode so they change only on CLK edges.
module run_ctrl #(
  parameter int START_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int MAX_CYCLES   = 20000
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req,
  input  logic             dp_done,
  output logic             dp_start,
  output logic             wr_inhibit,
  output logic             busy,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int INIT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {IDLE, INIT, RUN, FINISH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d, count_inc;
  logic              timeout_q, timeout_d;
  logic              dp_start_q, dp_start_d;
  logic              wr_inhibit_q, wr_inhibit_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    count_inc     = cycle_count_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d       = INIT;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
          init_cnt_d    = INIT_LOAD;
        end
      end
      INIT: begin
        if (init_cnt_q == '0) state_d = RUN;
        else                  init_cnt_d = init_cnt_q - INIT_W'(1);
      end
      RUN: begin
        // Done takes priority over the watchdog on the limit cycle.
        cycle_count_d = count_inc;
        if (dp_done) begin
          state_d   = FINISH;
          timeout_d = 1'b0;
        end else if (count_inc == CNT_MAX) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end
      end
      FINISH: state_d = DRAIN;
      DRAIN: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dp_start_d   = (state_d != RUN);
    wr_inhibit_d = (state_d != RUN);
    busy_d       = (state_d == INIT) || (state_d == RUN) || (state_d == FINISH);
    ack_d        = (state_d == FINISH);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= IDLE;
      init_cnt_q    <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      dp_start_q    <= 1'b1;
      wr_inhibit_q  <= 1'b1;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      dp_start_q    <= dp_start_d;
      wr_inhibit_q  <= wr_inhibit_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
    end
  end

  assign dp_start    = dp_start_q;
  assign wr_inhibit  = wr_inhibit_q;
  assign busy        = busy_q;
  assign ack         = ack_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - self-checking bench for run_ctrl
// Model tracks the age of the current run in cycles and derives every output from it.
module tb_run_ctrl;

  localparam int SC = 2;
  localparam int CW = 16;
  localparam int MC = 20;

  logic          CLK = 1'b0;
  logic          reset, req, dp_done;
  logic          dp_start, wr_inhibit, busy, ack, timeout;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int errors = 0;

  int m_age = 0;
  int m_fin = 0;
  int m_count = 0;
  bit m_drain = 1'b0;
  bit m_to = 1'b0;
  bit model_ok = 1'b0;

  always #5 CLK = ~CLK;

  run_ctrl #(.START_CYCLES(SC), .CNT_W(CW), .MAX_CYCLES(MC)) dut (
    .CLK(CLK), .reset(reset), .req(req), .dp_done(dp_done),
    .dp_start(dp_start), .wr_inhibit(wr_inhibit), .busy(busy), .ack(ack),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Age 1..SC is init, SC+1.. is run until the finishing age m_fin, after which the run drains.
  always @(posedge CLK) begin : model
    int age, fin, cnt;
    bit drain, to;
    age = m_age; fin = m_fin; cnt = m_count; drain = m_drain; to = m_to;
    if (reset) begin
      age = 0; fin = 0; cnt = 0; drain = 1'b0; to = 1'b0;
    end else if (drain) begin
      if (!req) drain = 1'b0;
    end else if (age == 0) begin
      if (req) begin
        age = 1; fin = 0; cnt = 0; to = 1'b0;
      end
    end else if (fin != 0 && age == fin) begin
      age = 0; drain = 1'b1;
    end else begin
      if (age > SC) begin
        cnt = age - SC;
        if (dp_done || cnt == MC) begin
          fin = age + 1;
          to  = !dp_done;
        end
      end
      age++;
    end
    m_age <= age; m_fin <= fin; m_count <= cnt; m_drain <= drain; m_to <= to;
    model_ok <= 1'b1;
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      check("dp_start", 32'(dp_start), 32'(!(m_age > SC && m_fin == 0)));
      check("wr_inhibit", 32'(wr_inhibit), 32'(!(m_age > SC && m_fin == 0)));
      check("busy", 32'(busy), 32'(m_age > 0));
      check("ack", 32'(ack), 32'(m_age > 0 && m_age == m_fin));
      check("timeout", 32'(timeout), 32'(m_to));
      check("cycle_count", 32'(cycle_count), 32'(m_count));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    bit seen;

    reset = 1'b1; req = 1'($urandom % 2); dp_done = 1'($urandom % 2);
    step();
    check("rst_dp_start", 32'(dp_start), 1);
    check("rst_wr_inhibit", 32'(wr_inhibit), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_count", 32'(cycle_count), 0);
    reset = 1'b0; req = 1'b0; dp_done = 1'b0;
    step(); step();

    // normal run: done sampled at end of run cycle 10
    req = 1'b1;
    step();
    check("n_c1_busy", 32'(busy), 1);
    check("n_c1_start", 32'(dp_start), 1);
    step();
    check("n_c2_start", 32'(dp_start), 1);
    step();
    check("n_c3_start", 32'(dp_start), 0);
    check("n_c3_wrinh", 32'(wr_inhibit), 0);
    repeat (9) step();
    check("n_c12_start", 32'(dp_start), 0);
    dp_done = 1'b1;
    step();
    check("n_ack", 32'(ack), 1);
    check("n_count", 32'(cycle_count), 10);
    check("n_timeout", 32'(timeout), 0);
    check("n_start_back", 32'(dp_start), 1);
    dp_done = 1'b0; req = 1'b0;
    step();
    check("n_ack_one", 32'(ack), 0);
    check("n_busy_off", 32'(busy), 0);
    step();

    // watchdog: no done, req held
    req = 1'b1; n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      step();
      n++;
      if (ack) seen = 1'b1;
    end
    check("wd_latency", 32'(n), 23);
    check("wd_count", 32'(cycle_count), 20);
    check("wd_timeout", 32'(timeout), 1);
    check("wd_start", 32'(dp_start), 1);

    repeat (50) step();
    check("hold_busy", 32'(busy), 0);
    check("hold_start", 32'(dp_start), 1);
    check("hold_count", 32'(cycle_count), 20);
    req = 1'b0;
    step();
    req = 1'b1;
    step();
    check("re_busy", 32'(busy), 1);
    check("re_count", 32'(cycle_count), 0);
    check("re_timeout", 32'(timeout), 0);

    // done on the limit cycle
    step(); step();
    repeat (19) step();
    dp_done = 1'b1;
    step();
    check("lim_ack", 32'(ack), 1);
    check("lim_timeout", 32'(timeout), 0);
    check("lim_count", 32'(cycle_count), 20);
    dp_done = 1'b0; req = 1'b0;
    step(); step();

    // stale done held through idle and init
    dp_done = 1'b1;
    step(); step();
    req = 1'b1;
    step(); step();
    check("stale_ack", 32'(ack), 0);
    step();
    check("stale_run", 32'(dp_start), 0);
    step();
    check("stale_ack2", 32'(ack), 1);
    check("stale_count", 32'(cycle_count), 1);
    dp_done = 1'b0; req = 1'b0;
    step(); step();

    // reset during run cycle 5
    req = 1'b1;
    step(); step(); step();
    repeat (4) step();
    check("mid_start", 32'(dp_start), 0);
    check("mid_count", 32'(cycle_count), 4);
    reset = 1'b1;
    step();
    check("mr_ack", 32'(ack), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_start", 32'(dp_start), 1);
    check("mr_count", 32'(cycle_count), 0);
    reset = 1'b0; req = 1'b0;
    repeat (3) step();
    check("mr_idle_ack", 32'(ack), 0);
    check("mr_idle_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
